dmem_arbiter: RTL and testbench

Shared data-memory stage directly downstream of `processor`: arbitrates load/store requests from the four cores onto one single-port data RAM.
- Round-robin grant, at most one access per cycle.
- Cores whose `end_op` bit is set are masked.
- After reset the RAM is zero-initialised before any core is served.

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_ram.sv | 36 +++
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 tb/tb_dmem_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types, defaults and helpers for the data-memory arbiter.
// Round-robin pick logic lives here so other stages can reuse it.
package dmem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } state_t;

    localparam int NUM_CORES_D = 4;
    localparam int ADDR_W_D    = 8;
    localparam int DATA_W_D    = 8;

    // One-hot pick of the first set bit of e, searching ptr, ptr+1, ... mod 4
    function automatic logic [3:0] rr_pick(
        input logic [3:0] e,
        input logic [1:0] ptr
    );
        logic [3:0] g;
        logic [1:0] idx;
        g = '0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (g == '0 && e[idx]) begin
                g[idx] = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous data RAM, one-cycle read latency.
// The array has no reset; only the read register is cleared.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_D,
    parameter int DATA_W = DATA_W_D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Array write port
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register: loads on a read access, holds otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Four-core round-robin arbiter in front of the shared data RAM.
// Clears the RAM after reset, then serves one access per cycle.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_D,
    parameter int ADDR_W    = ADDR_W_D,
    parameter int DATA_W    = DATA_W_D
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        req,
    input  logic [NUM_CORES-1:0]        we,
    input  logic [NUM_CORES*ADDR_W-1:0] addr,
    input  logic [NUM_CORES*DATA_W-1:0] wdata,
    input  logic [NUM_CORES-1:0]        end_op,
    output logic [NUM_CORES-1:0]        gnt,
    output logic [NUM_CORES-1:0]        rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        ready
);

    state_t               state;
    state_t               state_n;
    logic [ADDR_W-1:0]    clr_addr;
    logic [ADDR_W-1:0]    clr_addr_n;
    logic [1:0]           rr;
    logic [1:0]           rr_n;
    logic [NUM_CORES-1:0] rvalid_q;
    logic [NUM_CORES-1:0] rvalid_n;
    logic [NUM_CORES-1:0] elig;
    logic [NUM_CORES-1:0] gnt_w;
    logic [1:0]           gidx;
    logic                 sel_we;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic                 ram_en;
    logic                 ram_we;
    logic [ADDR_W-1:0]    ram_addr;
    logic [DATA_W-1:0]    ram_wdata;

    // Grant: masked requests, rotating priority, silent outside SERVE
    always_comb begin
        elig  = req & ~end_op;
        gnt_w = '0;
        if (!rst && state == SERVE) begin
            gnt_w = rr_pick(elig, rr);
        end
    end

    // Winner index and its request fields
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (gnt_w[i]) begin
                gidx = 2'(i);
            end
        end
        sel_we    = we[gidx];
        sel_addr  = addr[gidx*ADDR_W +: ADDR_W];
        sel_wdata = wdata[gidx*DATA_W +: DATA_W];
    end

    // Next-state, clear sweep, pointer advance and RAM port steering
    always_comb begin
        state_n    = state;
        clr_addr_n = clr_addr;
        rr_n       = rr;
        rvalid_n   = '0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = sel_addr;
        ram_wdata  = sel_wdata;
        unique case (state)
            CLEAR: begin
                ram_en     = !rst;
                ram_we     = 1'b1;
                ram_addr   = clr_addr;
                ram_wdata  = '0;
                clr_addr_n = clr_addr + 1'b1;
                if (clr_addr == '1) begin
                    state_n = SERVE;
                end
            end
            SERVE: begin
                if (|gnt_w) begin
                    ram_en = 1'b1;
                    ram_we = sel_we;
                    rr_n   = gidx + 2'd1;
                    if (!sel_we) begin
                        rvalid_n = gnt_w;
                    end
                end
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= CLEAR;
            clr_addr <= '0;
            rr       <= '0;
            rvalid_q <= '0;
        end else begin
            state    <= state_n;
            clr_addr <= clr_addr_n;
            rr       <= rr_n;
            rvalid_q <= rvalid_n;
        end
    end

    dmem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (rdata)
    );

    // A reset arriving while a load pulse is pending swallows that pulse
    assign rvalid = rst ? '0 : rvalid_q;
    assign gnt    = gnt_w;
    assign ready  = (state == SERVE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a load-result scoreboard.
// Grants are given per step; load data comes from a memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  we = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  end_op = '0;
    logic [3:0]  gnt;
    logic [3:0]  rvalid;
    logic [7:0]  rdata;
    logic        ready;

    typedef struct {
        logic [3:0] v;
        logic [7:0] d;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mmem [256];
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .NUM_CORES (4),
        .ADDR_W    (8),
        .DATA_W    (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .end_op (end_op),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata),
        .ready  (ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic [3:0] rq,
                       input logic [3:0] w, input logic [3:0] eo,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] eg);
        exp_t       e;
        int         k;
        logic [7:0] ad;
        rst = r;
        req = rq;
        we = w;
        end_op = eo;
        addr = a;
        wdata = d;
        @(negedge clk);
        chk("gnt", 32'(gnt), 32'(eg));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rvalid", 32'(rvalid), 32'(e.v));
            chk("rdata", 32'(rdata), 32'(e.d));
        end else begin
            chk("rvalid_idle", 32'(rvalid), 32'h0);
        end
        if (r) begin
            for (int i = 0; i < 256; i++) mmem[i] = 8'h00;
        end else if (eg != 4'b0) begin
            k = 0;
            for (int i = 0; i < 4; i++) if (eg[i]) k = i;
            ad = a[k*8 +: 8];
            if (w[k]) mmem[ad] = d[k*8 +: 8];
            else exp_q.push_back('{v: eg, d: mmem[ad]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_seq();
        for (int i = 0; i < 256; i++) begin
            chk("ready_clear", 32'(ready), 32'h0);
            cyc(1'b0, 4'hF, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0);
        end
        chk("ready_up", 32'(ready), 32'h1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mmem[i] = 8'h00;
        #1;
        cyc(1'b1, 4'hF, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0);
        cyc(1'b1, 4'hF, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0);
        chk("rst_rdata", 32'(rdata), 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        clear_seq();

        cyc(1'b0, 4'b0001, 4'b0000, 4'h0, 32'h00, 32'h0, 4'b0001);
        cyc(1'b0, 4'b0001, 4'b0000, 4'h0, 32'h7F, 32'h0, 4'b0001);
        cyc(1'b0, 4'b0001, 4'b0000, 4'h0, 32'hFF, 32'h0, 4'b0001);

        cyc(1'b0, 4'b0100, 4'b0100, 4'h0, 32'h00100000, 32'h00A50000, 4'b0100);
        cyc(1'b0, 4'b0100, 4'b0000, 4'h0, 32'h00100000, 32'h0, 4'b0100);
        cyc(1'b0, 4'b1000, 4'b0000, 4'h0, 32'h10000000, 32'h0, 4'b1000);

        cyc(1'b0, 4'b1111, 4'b0000, 4'h0, 32'h30102010, 32'h0, 4'b0001);
        cyc(1'b0, 4'b1111, 4'b0000, 4'h0, 32'h30102010, 32'h0, 4'b0010);
        cyc(1'b0, 4'b1111, 4'b0000, 4'h0, 32'h30102010, 32'h0, 4'b0100);
        cyc(1'b0, 4'b1111, 4'b0000, 4'h0, 32'h30102010, 32'h0, 4'b1000);
        cyc(1'b0, 4'b1111, 4'b0000, 4'h0, 32'h30102010, 32'h0, 4'b0001);

        cyc(1'b0, 4'b1010, 4'b0010, 4'h0, 32'h05000500, 32'h00001100, 4'b0010);
        cyc(1'b0, 4'b1000, 4'b0000, 4'h0, 32'h05000500, 32'h0, 4'b1000);

        cyc(1'b0, 4'b1111, 4'b0000, 4'b0101, 32'h05000500, 32'h0, 4'b0010);
        cyc(1'b0, 4'b1111, 4'b0000, 4'b0101, 32'h05000500, 32'h0, 4'b1000);
        cyc(1'b0, 4'b1111, 4'b0000, 4'b0101, 32'h05000500, 32'h0, 4'b0010);
        cyc(1'b0, 4'b1111, 4'b0000, 4'b0101, 32'h05000500, 32'h0, 4'b1000);
        cyc(1'b0, 4'b1111, 4'b0000, 4'b1111, 32'h05000500, 32'h0, 4'b0000);
        cyc(1'b0, 4'b0000, 4'b0000, 4'h0, 32'h0, 32'h0, 4'b0000);

        cyc(1'b0, 4'b0001, 4'b0001, 4'h0, 32'h20, 32'h3C, 4'b0001);
        cyc(1'b0, 4'b0001, 4'b0000, 4'h0, 32'h20, 32'h0, 4'b0001);
        exp_q.delete();
        cyc(1'b1, 4'b0001, 4'b0000, 4'h0, 32'h20, 32'h0, 4'b0000);
        clear_seq();
        cyc(1'b0, 4'b0001, 4'b0000, 4'h0, 32'h20, 32'h0, 4'b0001);
        cyc(1'b0, 4'b0000, 4'b0000, 4'h0, 32'h0, 32'h0, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
